alu_rtl: RTL and testbench

- Registered ALU responder: the device-under-test end of the ALU stimulus/monitor interface.
- Accepts operands, command, mode and carry-in under clock-enable; produces a 2*WIDTH result and flags.
- Completes partially-valid operand pairs within a timeout window.
- Multiply commands take one extra pipeline cycle.

---
 rtl/alu_pkg.sv | 65 ++++++
 rtl/alu_exec.sv | 104 ++++++++++
 rtl/alu_rtl.sv | 216 +++++++++++++++++++++
 tb/tb_alu_rtl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types, default widths and command-classification helpers for the
// registered ALU responder.
package alu_pkg;

    localparam int ALU_WIDTH     = 8;
    localparam int ALU_CMD_WIDTH = 4;

    typedef enum logic [3:0] {
        A_ADD     = 4'd0,
        A_SUB     = 4'd1,
        A_ADD_CIN = 4'd2,
        A_SUB_CIN = 4'd3,
        A_INC_A   = 4'd4,
        A_DEC_A   = 4'd5,
        A_INC_B   = 4'd6,
        A_DEC_B   = 4'd7,
        A_CMP     = 4'd8,
        A_MUL_INC = 4'd9,
        A_MUL_SHL = 4'd10
    } arith_cmd_e;

    typedef enum logic [3:0] {
        L_AND     = 4'd0,
        L_NAND    = 4'd1,
        L_OR      = 4'd2,
        L_NOR     = 4'd3,
        L_XOR     = 4'd4,
        L_XNOR    = 4'd5,
        L_NOT_A   = 4'd6,
        L_NOT_B   = 4'd7,
        L_SHR1_A  = 4'd8,
        L_SHL1_A  = 4'd9,
        L_SHR1_B  = 4'd10,
        L_SHL1_B  = 4'd11,
        L_ROL_A_B = 4'd12,
        L_ROR_A_B = 4'd13
    } logic_cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_OPS,
        MUL
    } state_e;

    function automatic logic cmd_ok(input logic mode, input logic [ALU_CMD_WIDTH-1:0] cmd);
        return mode ? (cmd <= A_MUL_SHL) : (cmd <= L_ROR_A_B);
    endfunction

    function automatic logic needs_a(input logic mode, input logic [ALU_CMD_WIDTH-1:0] cmd);
        if (mode)
            return !(cmd == A_INC_B || cmd == A_DEC_B);
        return !(cmd == L_NOT_B || cmd == L_SHR1_B || cmd == L_SHL1_B);
    endfunction

    function automatic logic needs_b(input logic mode, input logic [ALU_CMD_WIDTH-1:0] cmd);
        if (mode)
            return !(cmd == A_INC_A || cmd == A_DEC_A);
        return !(cmd == L_NOT_A || cmd == L_SHR1_A || cmd == L_SHL1_A);
    endfunction

    function automatic logic is_mul(input logic mode, input logic [ALU_CMD_WIDTH-1:0] cmd);
        return mode && (cmd == A_MUL_INC || cmd == A_MUL_SHL);
    endfunction

endpackage

// File: rtl/alu_exec.sv
// Purely combinational ALU datapath: result and flags from operands, command,
// mode and carry-in. Non-applicable flags are always 0.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH     = ALU_WIDTH,
    parameter int CMD_WIDTH = ALU_CMD_WIDTH
) (
    input  logic                 mode,
    input  logic                 cin,
    input  logic [CMD_WIDTH-1:0] cmd,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   res,
    output logic                 cout,
    output logic                 oflow,
    output logic                 g,
    output logic                 l,
    output logic                 e,
    output logic                 err
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]     a_x, b_x, cin_x, one_x, wide;
    logic [2*WIDTH-1:0] a_w, b_w, one_w;
    logic [WIDTH-1:0]   narrow, a_shl, rol, ror;
    logic [SHW-1:0]     amt, amt_n;

    assign a_x   = {1'b0, a};
    assign b_x   = {1'b0, b};
    assign cin_x = {{WIDTH{1'b0}}, cin};
    assign one_x = {{WIDTH{1'b0}}, 1'b1};
    assign a_w   = {{WIDTH{1'b0}}, a};
    assign b_w   = {{WIDTH{1'b0}}, b};
    assign one_w = {{(2*WIDTH-1){1'b0}}, 1'b1};
    assign a_shl = a << 1;

    // The complementary shift by (-amt mod WIDTH) wraps to zero for amt == 0,
    // so both terms equal a and the OR stays correct without a special case.
    assign amt   = b[SHW-1:0];
    assign amt_n = -amt;
    assign rol   = (a << amt) | (a >> amt_n);
    assign ror   = (a >> amt) | (a << amt_n);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        res    = '0;
        cout   = 1'b0;
        oflow  = 1'b0;
        g      = 1'b0;
        l      = 1'b0;
        e      = 1'b0;
        err    = 1'b0;
        wide   = '0;
        narrow = '0;
        if (mode) begin
            case (cmd)
                A_ADD:     begin wide = a_x + b_x;         cout  = wide[WIDTH]; end
                A_SUB:     begin wide = a_x - b_x;         oflow = (a_x < b_x); end
                A_ADD_CIN: begin wide = a_x + b_x + cin_x; cout  = wide[WIDTH]; end
                A_SUB_CIN: begin wide = a_x - b_x - cin_x; oflow = (a_x < b_x + cin_x); end
                A_INC_A:   begin wide = a_x + one_x;       cout  = wide[WIDTH]; end
                A_DEC_A:   begin wide = a_x - one_x;       oflow = (a == '0); end
                A_INC_B:   begin wide = b_x + one_x;       cout  = wide[WIDTH]; end
                A_DEC_B:   begin wide = b_x - one_x;       oflow = (b == '0); end
                A_CMP: begin
                    g = (a > b);
                    l = (a < b);
                    e = (a == b);
                end
                A_MUL_INC: ;
                A_MUL_SHL: ;
                default:   err = 1'b1;
            endcase
            if (cmd == A_MUL_INC)
                res = (a_w + one_w) * (b_w + one_w);
            else if (cmd == A_MUL_SHL)
                res = {{WIDTH{1'b0}}, a_shl} * b_w;
            else
                res = {{(WIDTH-1){1'b0}}, wide};
        end else begin
            case (cmd)
                L_AND:     narrow = a & b;
                L_NAND:    narrow = ~(a & b);
                L_OR:      narrow = a | b;
                L_NOR:     narrow = ~(a | b);
                L_XOR:     narrow = a ^ b;
                L_XNOR:    narrow = ~(a ^ b);
                L_NOT_A:   narrow = ~a;
                L_NOT_B:   narrow = ~b;
                L_SHR1_A:  narrow = a >> 1;
                L_SHL1_A:  narrow = a << 1;
                L_SHR1_B:  narrow = b >> 1;
                L_SHL1_B:  narrow = b << 1;
                L_ROL_A_B: begin narrow = rol; err = |b[WIDTH-1:SHW]; end
                L_ROR_A_B: begin narrow = ror; err = |b[WIDTH-1:SHW]; end
                default:   err = 1'b1;
            endcase
            res = {{WIDTH{1'b0}}, narrow};
        end
    end

endmodule

// File: rtl/alu_rtl.sv
// Registered ALU responder: operand collection FSM with timeout, one-cycle
// multiply pipeline stage and registered result/flag outputs.
module alu_rtl
    import alu_pkg::*;
#(
    parameter int WIDTH     = ALU_WIDTH,
    parameter int CMD_WIDTH = ALU_CMD_WIDTH,
    parameter int TIMEOUT   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 MODE,
    input  logic                 CIN,
    input  logic [1:0]           INP_VALID,
    input  logic [CMD_WIDTH-1:0] CMD,
    input  logic [WIDTH-1:0]     OPA,
    input  logic [WIDTH-1:0]     OPB,
    output logic [2*WIDTH-1:0]   RES,
    output logic                 COUT,
    output logic                 OFLOW,
    output logic                 G,
    output logic                 L,
    output logic                 E,
    output logic                 ERR
);

    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic                 mode_q, mode_d, cin_q, cin_d;
    logic [1:0]           valid_q, valid_d, merged;

    logic [2*WIDTH-1:0]   res_d;
    logic                 cout_d, oflow_d, g_d, l_d, e_d, err_d;

    logic                 x_mode, x_cin;
    logic [CMD_WIDTH-1:0] x_cmd;
    logic [WIDTH-1:0]     x_a, x_b;
    logic [2*WIDTH-1:0]   x_res;
    logic                 x_cout, x_oflow, x_g, x_l, x_e, x_err;
    logic                 upd, fault;

    alu_exec #(.WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH)) u_exec (
        .mode  (x_mode),
        .cin   (x_cin),
        .cmd   (x_cmd),
        .a     (x_a),
        .b     (x_b),
        .res   (x_res),
        .cout  (x_cout),
        .oflow (x_oflow),
        .g     (x_g),
        .l     (x_l),
        .e     (x_e),
        .err   (x_err)
    );

    assign merged = valid_q | INP_VALID;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cmd_d   = cmd_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        valid_d = valid_q;
        x_mode  = MODE;
        x_cin   = CIN;
        x_cmd   = CMD;
        x_a     = OPA;
        x_b     = OPB;
        upd     = 1'b0;
        fault   = 1'b0;

        case (state_q)
            IDLE: begin
                if (INP_VALID == 2'b00 || !cmd_ok(MODE, CMD)) begin
                    fault = 1'b1;
                end else if ((!needs_a(MODE, CMD) || INP_VALID[0]) &&
                             (!needs_b(MODE, CMD) || INP_VALID[1])) begin
                    if (is_mul(MODE, CMD)) begin
                        a_d     = OPA;
                        b_d     = OPB;
                        cmd_d   = CMD;
                        mode_d  = MODE;
                        cin_d   = CIN;
                        state_d = MUL;
                    end else begin
                        upd = 1'b1;
                    end
                end else if (needs_a(MODE, CMD) && needs_b(MODE, CMD)) begin
                    cmd_d   = CMD;
                    mode_d  = MODE;
                    cin_d   = CIN;
                    valid_d = INP_VALID;
                    if (INP_VALID[0]) a_d = OPA;
                    if (INP_VALID[1]) b_d = OPB;
                    cnt_d   = CNT_ONE;
                    state_d = WAIT_OPS;
                end else begin
                    // Single-operand command presented with only the other operand.
                    fault = 1'b1;
                end
            end

            WAIT_OPS: begin
                x_mode  = mode_q;
                x_cin   = cin_q;
                x_cmd   = cmd_q;
                x_a     = INP_VALID[0] ? OPA : a_q;
                x_b     = INP_VALID[1] ? OPB : b_q;
                a_d     = x_a;
                b_d     = x_b;
                valid_d = merged;
                if (merged == 2'b11) begin
                    cnt_d = '0;
                    if (is_mul(mode_q, cmd_q)) begin
                        state_d = MUL;
                    end else begin
                        upd     = 1'b1;
                        state_d = IDLE;
                    end
                end else if (cnt_q == TMO) begin
                    fault   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            MUL: begin
                x_mode  = mode_q;
                x_cin   = cin_q;
                x_cmd   = cmd_q;
                x_a     = a_q;
                x_b     = b_q;
                upd     = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        res_d   = RES;
        cout_d  = COUT;
        oflow_d = OFLOW;
        g_d     = G;
        l_d     = L;
        e_d     = E;
        err_d   = ERR;
        if (fault) begin
            res_d   = '0;
            cout_d  = 1'b0;
            oflow_d = 1'b0;
            g_d     = 1'b0;
            l_d     = 1'b0;
            e_d     = 1'b0;
            err_d   = 1'b1;
        end else if (upd) begin
            res_d   = x_res;
            cout_d  = x_cout;
            oflow_d = x_oflow;
            g_d     = x_g;
            l_d     = x_l;
            e_d     = x_e;
            err_d   = x_err;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            valid_q <= 2'b00;
            RES     <= '0;
            COUT    <= 1'b0;
            OFLOW   <= 1'b0;
            G       <= 1'b0;
            L       <= 1'b0;
            E       <= 1'b0;
            ERR     <= 1'b0;
        end else if (CE) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cmd_q   <= cmd_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            valid_q <= valid_d;
            RES     <= res_d;
            COUT    <= cout_d;
            OFLOW   <= oflow_d;
            G       <= g_d;
            L       <= l_d;
            E       <= e_d;
            ERR     <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_rtl.sv
// Self-checking bench for alu_rtl: directed protocol scenarios followed by
// randomized single-transaction traffic against an integer reference model.
module tb_alu_rtl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CE;
    logic        MODE;
    logic        CIN;
    logic [1:0]  INP_VALID;
    logic [3:0]  CMD;
    logic [7:0]  OPA;
    logic [7:0]  OPB;
    logic [15:0] RES;
    logic        COUT, OFLOW, G, L, E, ERR;

    int          nvec  = 0;
    int          nfail = 0;
    logic [21:0] last  = '0;
    wire  [21:0] obs   = {RES, COUT, OFLOW, G, L, E, ERR};

    alu_rtl #(.WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .MODE      (MODE),
        .CIN       (CIN),
        .INP_VALID (INP_VALID),
        .CMD       (CMD),
        .OPA       (OPA),
        .OPB       (OPB),
        .RES       (RES),
        .COUT      (COUT),
        .OFLOW     (OFLOW),
        .G         (G),
        .L         (L),
        .E         (E),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    // Expected bundle layout: {res[15:0], cout, oflow, g, l, e, err}
    function automatic logic [21:0] mk(input int res, input bit co, input bit ov,
                                       input bit gg, input bit ll, input bit ee, input bit er);
        logic [15:0] r;
        r = 16'(res);
        return {r, co, ov, gg, ll, ee, er};
    endfunction

    // Reference model: plain integer arithmetic straight from the command table.
    function automatic logic [21:0] ref_model(input bit mode, input int cmd, input int a,
                                              input int b, input bit cin);
        int r;
        bit co, ov, gg, ll, ee, er;
        r = 0; co = 0; ov = 0; gg = 0; ll = 0; ee = 0; er = 0;
        if (mode) begin
            case (cmd)
                0:  begin r = a + b;                 co = (r > 255); end
                1:  begin r = (a - b) & 'h1FF;       ov = (a < b); end
                2:  begin r = a + b + cin;           co = (r > 255); end
                3:  begin r = (a - b - cin) & 'h1FF; ov = (a < b + cin); end
                4:  begin r = a + 1;                 co = (r > 255); end
                5:  begin r = (a - 1) & 'h1FF;       ov = (a == 0); end
                6:  begin r = b + 1;                 co = (r > 255); end
                7:  begin r = (b - 1) & 'h1FF;       ov = (b == 0); end
                8:  begin gg = (a > b); ll = (a < b); ee = (a == b); end
                9:  r = ((a + 1) * (b + 1)) % 65536;
                10: r = (((a * 2) % 256) * b) % 65536;
                default: er = 1;
            endcase
        end else begin
            case (cmd)
                0:  r = a & b;
                1:  r = 255 - (a & b);
                2:  r = a | b;
                3:  r = 255 - (a | b);
                4:  r = a ^ b;
                5:  r = 255 - (a ^ b);
                6:  r = 255 - a;
                7:  r = 255 - b;
                8:  r = a / 2;
                9:  r = (a * 2) % 256;
                10: r = b / 2;
                11: r = (b * 2) % 256;
                12: begin r = ((a << (b % 8)) | (a >> (8 - b % 8))) % 256; er = (b > 7); end
                13: begin r = ((a >> (b % 8)) | (a << (8 - b % 8))) % 256; er = (b > 7); end
                default: er = 1;
            endcase
        end
        return mk(r, co, ov, gg, ll, ee, er);
    endfunction

    task automatic chk(input string tag, input logic [21:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed res=%h flags(co,ov,g,l,e,err)=%b expected res=%h flags=%b",
                   tag, obs[21:6], obs[5:0], exp[21:6], exp[5:0]);
        end
        last = exp;
    endtask

    task automatic put(input bit mode, input int cmd, input int a, input int b,
                       input logic [1:0] iv, input bit cin);
        MODE      = mode;
        CMD       = 4'(cmd);
        OPA       = 8'(a);
        OPB       = 8'(b);
        INP_VALID = iv;
        CIN       = cin;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bit          rm, rc;
        int          rcmd, ra, rb;

        RST = 1'b0;
        CE  = 1'b1;
        put(0, 0, 0, 0, 2'b00, 0);
        #2;
        chk("reset", mk(0, 0, 0, 0, 0, 0, 0));
        step();
        chk("reset_hold", mk(0, 0, 0, 0, 0, 0, 0));
        #2 RST = 1'b1;

        put(1, 0, 'hFF, 'h01, 2'b11, 0); step();
        chk("add_ff_01", mk('h0100, 1, 0, 0, 0, 0, 0));

        put(1, 8, 5, 9, 2'b11, 0); step();
        chk("cmp_lt", mk(0, 0, 0, 0, 1, 0, 0));
        put(1, 8, 7, 7, 2'b11, 0); step();
        chk("cmp_eq", mk(0, 0, 0, 0, 0, 1, 0));
        put(1, 8, 9, 5, 2'b11, 0); step();
        chk("cmp_gt", mk(0, 0, 0, 1, 0, 0, 0));

        put(1, 9, 3, 4, 2'b11, 0); step();
        chk("mul_lat1_hold", last);
        INP_VALID = 2'b00; step();
        chk("mul_inc", mk(20, 0, 0, 0, 0, 0, 0));

        // Partial operands: A now, B four cycles later; CMD changes are ignored.
        put(1, 0, 10, 0, 2'b01, 0); step();
        chk("wait_entry_hold", last);
        put(1, 7, 0, 0, 2'b00, 0);
        repeat (3) step();
        chk("wait_idle_hold", last);
        put(1, 7, 0, 6, 2'b10, 0); step();
        chk("wait_merge", mk(16, 0, 0, 0, 0, 0, 0));

        put(1, 0, 0, 5, 2'b10, 0); step();
        INP_VALID = 2'b00;
        repeat (15) step();
        chk("timeout_15_hold", last);
        step();
        chk("timeout_16", mk(0, 0, 0, 0, 0, 0, 1));

        put(1, 0, 1, 1, 2'b11, 0); step();
        chk("add_after_tmo", mk(2, 0, 0, 0, 0, 0, 0));
        put(1, 0, 4, 0, 2'b01, 0); step();
        INP_VALID = 2'b00;
        for (int i = 0; i < 15; i++) begin
            CE = 1'b1; step();
            if (i < 5) begin
                CE = 1'b0; step();
            end
        end
        CE = 1'b1;
        chk("timeout_ce_hold", last);
        step();
        chk("timeout_ce", mk(0, 0, 0, 0, 0, 0, 1));

        CE = 1'b0;
        put(1, 0, 3, 4, 2'b11, 0); step();
        chk("ce_freeze", last);
        CE = 1'b1; step();
        chk("ce_resume", mk(7, 0, 0, 0, 0, 0, 0));

        put(1, 0, 3, 4, 2'b00, 0); step();
        chk("no_valid_err", mk(0, 0, 0, 0, 0, 0, 1));
        put(1, 11, 3, 4, 2'b11, 0); step();
        chk("undef_arith", mk(0, 0, 0, 0, 0, 0, 1));
        put(0, 14, 3, 4, 2'b11, 0); step();
        chk("undef_logic", mk(0, 0, 0, 0, 0, 0, 1));

        put(1, 1, 3, 5, 2'b11, 0); step();
        chk("sub_under", mk('h1FE, 0, 1, 0, 0, 0, 0));
        put(1, 5, 0, 0, 2'b01, 0); step();
        chk("dec_zero", mk('h1FF, 0, 1, 0, 0, 0, 0));
        put(1, 3, 5, 5, 2'b11, 1); step();
        chk("sub_cin_under", mk('h1FF, 0, 1, 0, 0, 0, 0));
        put(1, 2, 'hFF, 'hFF, 2'b11, 1); step();
        chk("add_cin_max", mk('h1FF, 1, 0, 0, 0, 0, 0));
        put(1, 6, 0, 'hFF, 2'b10, 0); step();
        chk("inc_b_wrap", mk('h100, 1, 0, 0, 0, 0, 0));

        put(0, 12, 'h81, 'h11, 2'b11, 0); step();
        chk("rol_err", mk('h03, 0, 0, 0, 0, 0, 1));
        put(0, 13, 'h81, 'h01, 2'b11, 0); step();
        chk("ror_1", mk('hC0, 0, 0, 0, 0, 0, 0));

        put(1, 10, 'h85, 3, 2'b11, 0); step();
        INP_VALID = 2'b00;
        RST = 1'b0;
        #1;
        chk("rst_in_mul", mk(0, 0, 0, 0, 0, 0, 0));
        #2 RST = 1'b1;
        put(1, 0, 2, 3, 2'b11, 0); step();
        chk("after_rst", mk(5, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 200; i++) begin
            rm   = 1'($urandom_range(0, 1));
            rcmd = rm ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 13));
            ra   = int'($urandom_range(0, 255));
            rb   = int'($urandom_range(0, 255));
            rc   = 1'($urandom_range(0, 1));
            put(rm, rcmd, ra, rb, 2'b11, rc);
            step();
            if (rm && rcmd >= 9) begin
                INP_VALID = 2'b00;
                step();
            end
            chk("random", ref_model(rm, rcmd, ra, rb, rc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
